// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter for two write-back requesters.
//   A: in-order MEM/WB stage, B: multi-cycle unit (mult/div, late load).
// Each requester owns a one-entry holding buffer; a registered arbiter drives
// the single register file write port. Decode hazard flags cover results that
// are still held here, because the register file bypass only sees the active write.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   a_valid/a_ready/a_addr/a_data   requester A handshake and payload
//   b_valid/b_ready/b_addr/b_data   requester B handshake and payload
//   raddr1/re1, raddr2/re2    decode read ports
//   hz1, hz2                  read port hits a held (unwritten) result
//   reg_we/reg_waddr/reg_wdata  registered register file write port
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic              re1,
  input  logic              re2,
  output logic              hz1,
  output logic              hz2,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_waddr,
  output logic [DATA_W-1:0] reg_wdata
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic              ha_v, hb_v;
  logic [ADDR_W-1:0] ha_addr, hb_addr;
  logic [DATA_W-1:0] ha_data, hb_data;
  logic              b_older;
  logic [CNT_W-1:0]  starve_cnt;

  logic grant_a, grant_b;
  logic a_load, b_load;
  logic a_keep, b_keep;
  logic hit1, hit2;

  // One grant per cycle: sole entry wins; same address goes to the older
  // entry; otherwise A wins unless B has starved for STARVE_MAX cycles.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (ha_v && hb_v) begin
      if (ha_addr == hb_addr) begin
        grant_b = b_older;
        grant_a = !b_older;
      end else if (starve_cnt == CNT_MAX) begin
        grant_b = 1'b1;
      end else begin
        grant_a = 1'b1;
      end
    end else begin
      grant_a = ha_v;
      grant_b = hb_v;
    end
  end

  // A buffer frees up in the same cycle it is granted.
  assign a_ready = !rst && (!ha_v || grant_a);
  assign b_ready = !rst && (!hb_v || grant_b);

  // Writes to x0 are accepted but never buffered.
  assign a_load = a_valid && a_ready && (a_addr != '0);
  assign b_load = b_valid && b_ready && (b_addr != '0);

  assign a_keep = ha_v && !grant_a;
  assign b_keep = hb_v && !grant_b;

  // Held entries only; the entry on reg_we is forwarded by the register file.
  assign hit1 = (ha_v && (ha_addr == raddr1)) || (hb_v && (hb_addr == raddr1));
  assign hit2 = (ha_v && (ha_addr == raddr2)) || (hb_v && (hb_addr == raddr2));
  assign hz1  = !rst && re1 && (raddr1 != '0) && hit1;
  assign hz2  = !rst && re2 && (raddr2 != '0) && hit2;

  // Buffer payloads: no reset needed, qualified by the valid flags.
  always_ff @(posedge clk) begin
    if (a_load) begin
      ha_addr <= a_addr;
      ha_data <= a_data;
    end
    if (b_load) begin
      hb_addr <= b_addr;
      hb_data <= b_data;
    end
  end

  // Valid flags, age flag, starvation counter and the write-port register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ha_v       <= 1'b0;
      hb_v       <= 1'b0;
      b_older    <= 1'b0;
      starve_cnt <= '0;
      reg_we     <= 1'b0;
      reg_waddr  <= '0;
      reg_wdata  <= '0;
    end else begin
      ha_v <= a_load || a_keep;
      hb_v <= b_load || b_keep;

      // Simultaneous loads treat B as older.
      if (a_load && b_load) begin
        b_older <= 1'b1;
      end else if (a_load) begin
        b_older <= b_keep;
      end else if (b_load) begin
        b_older <= !a_keep;
      end

      if (!hb_v || grant_b) begin
        starve_cnt <= '0;
      end else if (grant_a && (starve_cnt != CNT_MAX)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end

      reg_we <= grant_a || grant_b;
      if (grant_a) begin
        reg_waddr <= ha_addr;
        reg_wdata <= ha_data;
      end else if (grant_b) begin
        reg_waddr <= hb_addr;
        reg_wdata <= hb_data;
      end
    end
  end

endmodule
